rf_controller: RTL
==================

# rf_controller

Multi-cycle instruction sequencer that drives the 8×4-bit, two-read/one-write register file from its initiator side. It accepts one 12-bit instruction at a time over a valid/ready handshake, and for each instruction it:
- issues the register-file read addresses,
- latches the read data,
- computes a 4-bit ALU result,
- issues the write-back (`en`/`wra`/`wrd`) or a register-file clear (`rf_clr`).

It sits between the instruction source (switch/button front end or instruction memory) and the register file.

## Interface
Parameters:
- `CNT_W`, 8, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `clr`  in  1  synchronous, active-high reset
- `instr`  in  12  instruction word
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  controller can accept instruction
- `rda1`  out  3  register file read address 1 = `ir[5:3]`
- `rda2`  out  3  register file read address 2 = `ir[2:0]`
- `rdd1`  in  4  register file read data 1 (combinational from `rda1`)
- `rdd2`  in  4  register file read data 2
- `wra`  out  3  write address = `ir[8:6]`
- `wrd`  out  4  write data
- `en`  out  1  write enable
- `rf_clr`  out  1  register file clear (file resets all entries to 1)
- `result`  out  4  last ALU result
- `halted`  out  1  HALT executed
- `retired`  out  `CNT_W`  count of completed instructions

One clock; reset is synchronous and active-high (`clk`, `clr`).

## Operation
Instruction fields:
- `op = ir[11:9]`, `dst = ir[8:6]`, `src1 = ir[5:3]`, `src2 = ir[2:0]`, `imm = ir[3:0]`

Opcodes:
- 000 NOP
- 001 LDI: `dst ← imm`
- 010 ADD: `dst ← src1 + src2`
- 011 SUB: `dst ← src1 − src2`
- 100 AND
- 101 OR
- 110 CLR: pulse `rf_clr`
- 111 HALT

Arithmetic:
- All arithmetic is 4-bit modulo 16; carry and borrow are discarded.

FSM states: IDLE, DECODE, EXEC, WB, HALT.
- IDLE: `instr_ready=1`. On `instr_valid & instr_ready`, capture `instr` into `ir`, go to DECODE.
- DECODE: `rda1`/`rda2` driven from `ir`; latch `rdd1`/`rdd2` into `opa`/`opb` at the clock edge. Go to EXEC.
- EXEC: `alu_q ← f(op, opa, opb, imm)`; `result` updates at the end of this cycle for LDI/ADD/SUB/AND/OR only. Go to WB.
- WB:
  - `en=1` for LDI/ADD/SUB/AND/OR, with `wra=dst`, `wrd=alu_q`.
  - `rf_clr=1` for CLR.
  - Neither for NOP/HALT.
  - `retired` increments (wraps at 2^CNT_W).
  - Next state is HALT if op=HALT, else IDLE.
- HALT: `halted=1`, `instr_ready=0`. Only `clr` exits.

Output behaviour outside the states above:
- `en` and `rf_clr` are 0 in every state other than WB (except during reset, below).
- `rda1`/`rda2`/`wra` always reflect `ir`.
- `wrd` always reflects `alu_q`.

Reset (`clr=1` at an edge):
- state ← IDLE
- `ir`, `opa`, `opb`, `alu_q`, `result`, `retired` ← 0
- `halted` ← 0
- `rf_clr` is driven 1 combinationally while `clr=1`, so the register file clears alongside the controller.
- `clr` has priority over everything. If asserted mid-instruction (DECODE/EXEC/WB), the instruction is abandoned: no `en` is issued in the following cycle and `retired` is not incremented.
- Reset values of the outputs, with `ir=0`: `instr_ready=1` once out of reset, `en=0`, `rda1=rda2=wra=0`, `wrd=0`, `result=0`, `halted=0`, `retired=0`.

## Timing
- Handshake: the instruction is accepted at edge T (valid & ready high in cycle T−1→T).
- Cycle sequence after acceptance: DECODE in cycle T, EXEC in T+1, WB in T+2; the register file write occurs at the edge ending T+2.
- `instr_ready` is high again in cycle T+3.
- Throughput: one instruction per 4 cycles.
- `instr_valid` while `instr_ready=0` is ignored; the source must hold it.
- Operands are sampled in DECODE only. A write issued in WB is visible to the next instruction's DECODE with no hazard.
- An instruction reading and writing the same register (e.g. ADD r2,r2,r2) uses the old value.

## Structure
- Package `rf_ctrl_pkg` holds:
  - `opcode_t` enum (3 bits)
  - `state_t` enum
  - field-position localparams (`OP_HI`/`OP_LO`, `DST_*`, `SRC1_*`, `SRC2_*`, `IMM_*`)
  - `DATA_W=4`, `ADDR_W=3`
- Sub-module `alu4`: combinational; inputs `op`, `a`, `b`, `imm`; output `y`.
- All sequencing stays in `rf_controller`.

## Test plan
- LDI: after reset, send `instr=001_011_000_101` → `en=1`, `wra=3`, `wrd=5` exactly 3 cycles after acceptance; `retired=1`.
- ADD wrap: with r1=9, r2=8 (model file attached), send ADD r4,r1,r2 → `wrd=1`, `wra=4`, `result=1`.
- SUB borrow: with r1=2, r2=5, send SUB r0,r1,r2 → `wrd=13`.
- CLR then read: send CLR → one-cycle `rf_clr` in WB, `en=0`; then ADD r5,r0,r7 → `wrd=2`.
- HALT: send HALT → `halted=1` and `instr_ready=0`; a further valid LDI produces no `en` for 20 cycles; `clr` restores `instr_ready=1` and `halted=0`.
- Reset mid-operation: assert `clr` during EXEC of an ADD → no `en` in the next cycle, `retired=0`, state IDLE, `rf_clr=1` during the `clr` cycle.

Source files
------------

// File: rtl/rf_controller_pkg.sv
// Shared types and field positions for the register-file instruction sequencer.
package rf_ctrl_pkg;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 12;

    // Instruction field positions
    localparam int OP_HI   = 11;
    localparam int OP_LO   = 9;
    localparam int DST_HI  = 8;
    localparam int DST_LO  = 6;
    localparam int SRC1_HI = 5;
    localparam int SRC1_LO = 3;
    localparam int SRC2_HI = 2;
    localparam int SRC2_LO = 0;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_CLR  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // True for the opcodes that write a register and update the result.
    function automatic logic writes_rf(input opcode_t op);
        logic w;
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: w = 1'b1;
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rf_controller_alu4.sv
// 4-bit combinational ALU; arithmetic wraps modulo 16.
module alu4
    import rf_ctrl_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y
);

    // Select the operation result; non-computing opcodes yield zero.
    always_comb begin
        y = 4'h0;
        case (op)
            OP_LDI:  y = imm;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/rf_controller.sv
// Four-cycle sequencer driving a 2-read/1-write 8x4 register file.
module rf_controller
    import rf_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [ADDR_W-1:0]   rda1,
    output logic [ADDR_W-1:0]   rda2,
    input  logic [DATA_W-1:0]   rdd1,
    input  logic [DATA_W-1:0]   rdd2,
    output logic [ADDR_W-1:0]   wra,
    output logic [DATA_W-1:0]   wrd,
    output logic                en,
    output logic                rf_clr,
    output logic [DATA_W-1:0]   result,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [INSTR_W-1:0]   ir_r;
    logic [DATA_W-1:0]    opa_r;
    logic [DATA_W-1:0]    opb_r;
    logic [DATA_W-1:0]    alu_q_r;
    logic [DATA_W-1:0]    result_r;
    logic [CNT_W-1:0]     retired_r;
    logic                 halted_r;
    opcode_t              op_s;
    logic [DATA_W-1:0]    alu_y_s;

    assign op_s = opcode_t'(ir_r[OP_HI:OP_LO]);

    alu4 u_alu (
        .op  (op_s),
        .a   (opa_r),
        .b   (opb_r),
        .imm (ir_r[IMM_HI:IMM_LO]),
        .y   (alu_y_s)
    );

    // State register; clr returns to IDLE from anywhere, including HALT.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs.
    always_comb begin
        state_nxt_s = state_r;
        instr_ready = 1'b0;
        en          = 1'b0;
        rf_clr      = clr;
        case (state_r)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DECODE: state_nxt_s = ST_EXEC;
            ST_EXEC:   state_nxt_s = ST_WB;
            ST_WB: begin
                // A write coinciding with clr is suppressed: the instruction is abandoned.
                en     = writes_rf(op_s) & ~clr;
                rf_clr = clr | (op_s == OP_CLR);
                if (op_s == OP_HALT) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath registers: instruction capture, operand latch, ALU result, counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            ir_r      <= '0;
            opa_r     <= '0;
            opb_r     <= '0;
            alu_q_r   <= '0;
            result_r  <= '0;
            retired_r <= '0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir_r <= instr;
                    end else begin
                        ir_r <= ir_r;
                    end
                end
                ST_DECODE: begin
                    opa_r <= rdd1;
                    opb_r <= rdd2;
                end
                ST_EXEC: begin
                    alu_q_r <= alu_y_s;
                    if (writes_rf(op_s)) begin
                        result_r <= alu_y_s;
                    end else begin
                        result_r <= result_r;
                    end
                end
                ST_WB: begin
                    retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (op_s == OP_HALT) begin
                        halted_r <= 1'b1;
                    end else begin
                        halted_r <= halted_r;
                    end
                end
                default: begin
                    ir_r <= ir_r;
                end
            endcase
        end
    end

    assign rda1    = ir_r[SRC1_HI:SRC1_LO];
    assign rda2    = ir_r[SRC2_HI:SRC2_LO];
    assign wra     = ir_r[DST_HI:DST_LO];
    assign wrd     = alu_q_r;
    assign result  = result_r;
    assign retired = retired_r;
    assign halted  = halted_r;

endmodule
